// File: rtl/dsp_mac_sequencer.sv
// Sequences one dsp slice as an unsigned multiply-accumulate engine: takes a length
// command, streams A/B pairs into the slice, then returns the accumulated P.
module dsp_mac_sequencer #(
  parameter int LEN_WIDTH = 10,
  parameter int ABD_WIDTH = 18,
  parameter int CP_WIDTH  = 48
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CMD_VALID,
  output logic                 CMD_READY,
  input  logic [LEN_WIDTH-1:0] CMD_LEN,
  input  logic                 OP_VALID,
  output logic                 OP_READY,
  input  logic [ABD_WIDTH-1:0] OP_A,
  input  logic [ABD_WIDTH-1:0] OP_B,
  output logic                 RES_VALID,
  input  logic                 RES_READY,
  output logic [CP_WIDTH-1:0]  RES,
  output logic [ABD_WIDTH-1:0] DSP_A,
  output logic [ABD_WIDTH-1:0] DSP_B,
  output logic [7:0]           DSP_OPMODE,
  output logic                 DSP_CE,
  input  logic [CP_WIDTH-1:0]  DSP_P
);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_HOLD} state_t;

  localparam logic [7:0] OPM_FIRST = 8'h01;  // P = M
  localparam logic [7:0] OPM_ACC   = 8'h09;  // P = M + P
  localparam logic [7:0] OPM_HOLD  = 8'h08;  // P = P

  state_t               r_state, w_state_nxt;
  logic [LEN_WIDTH-1:0] r_remain, w_remain_nxt;
  logic [1:0]           r_drain, w_drain_nxt;
  logic                 r_first, w_first_nxt;
  logic [CP_WIDTH-1:0]  r_res, w_res_nxt;
  logic [7:0]           r_opmode, w_opmode_nxt;
  logic                 r_ce;
  logic                 w_acc;

  assign w_acc      = OP_VALID && (r_state == S_FEED);
  assign CMD_READY  = (r_state == S_IDLE);
  assign OP_READY   = (r_state == S_FEED);
  assign RES_VALID  = (r_state == S_HOLD);
  assign RES        = r_res;
  assign DSP_A      = w_acc ? OP_A : '0;
  assign DSP_B      = w_acc ? OP_B : '0;
  assign DSP_OPMODE = r_opmode;
  assign DSP_CE     = r_ce;

  always_comb begin
    w_state_nxt  = r_state;
    w_remain_nxt = r_remain;
    w_drain_nxt  = r_drain;
    w_first_nxt  = r_first;
    w_res_nxt    = r_res;
    w_opmode_nxt = OPM_HOLD;
    // The slice registers OPMODE one cycle after the operands, matching the M stage.
    if (w_acc) begin
      w_opmode_nxt = r_first ? OPM_FIRST : OPM_ACC;
    end
    case (r_state)
      S_IDLE: begin
        if (CMD_VALID) begin
          w_remain_nxt = CMD_LEN;
          w_first_nxt  = 1'b1;
          if (CMD_LEN == '0) begin
            w_res_nxt   = '0;
            w_state_nxt = S_HOLD;
          end else begin
            w_state_nxt = S_FEED;
          end
        end
      end
      S_FEED: begin
        if (w_acc) begin
          w_remain_nxt = r_remain - LEN_WIDTH'(1);
          w_first_nxt  = 1'b0;
          if (r_remain == LEN_WIDTH'(1)) begin
            w_drain_nxt = 2'd3;
            w_state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        w_drain_nxt = r_drain - 2'd1;
        // Last product reaches P two edges after acceptance; sample on the third.
        if (r_drain == 2'd1) begin
          w_res_nxt   = DSP_P;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (RES_READY) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_remain <= '0;
      r_drain  <= '0;
      r_first  <= 1'b0;
      r_res    <= '0;
      r_opmode <= 8'h00;
      r_ce     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_remain <= w_remain_nxt;
      r_drain  <= w_drain_nxt;
      r_first  <= w_first_nxt;
      r_res    <= w_res_nxt;
      r_opmode <= w_opmode_nxt;
      r_ce     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer with a behavioural dsp slice model and a
// queue of expected sums.
module tb_dsp_mac_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CMD_VALID = 1'b0;
  logic        CMD_READY;
  logic [9:0]  CMD_LEN = '0;
  logic        OP_VALID = 1'b0;
  logic        OP_READY;
  logic [17:0] OP_A = '0;
  logic [17:0] OP_B = '0;
  logic        RES_VALID;
  logic        RES_READY = 1'b0;
  logic [47:0] RES;
  logic [17:0] DSP_A, DSP_B;
  logic [7:0]  DSP_OPMODE;
  logic        DSP_CE;
  logic [47:0] DSP_P;

  int n_checks = 0;
  int n_fail   = 0;
  logic [47:0] exp_q[$];

  always #5 CLK = ~CLK;

  dsp_mac_sequencer dut (
    .CLK(CLK), .RST(RST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_LEN(CMD_LEN),
    .OP_VALID(OP_VALID), .OP_READY(OP_READY), .OP_A(OP_A), .OP_B(OP_B),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES(RES),
    .DSP_A(DSP_A), .DSP_B(DSP_B), .DSP_OPMODE(DSP_OPMODE), .DSP_CE(DSP_CE),
    .DSP_P(DSP_P)
  );

  // Slice model: operand regs, M reg, OPMODE reg, P reg; X=M when OPMODE[1:0]=01, Z=P when OPMODE[3:2]=10.
  logic [17:0] s_a1 = '0, s_b1 = '0;
  logic [35:0] s_m  = '0;
  logic [7:0]  s_op = '0;
  logic [47:0] s_p  = '0;
  logic [47:0] s_x, s_z;
  assign s_x   = (s_op[1:0] == 2'b01) ? {12'd0, s_m} : 48'd0;
  assign s_z   = (s_op[3:2] == 2'b10) ? s_p : 48'd0;
  assign DSP_P = s_p;

  always @(posedge CLK) begin
    if (DSP_CE) begin
      s_a1 <= DSP_A;
      s_b1 <= DSP_B;
      s_m  <= s_a1 * s_b1;
      s_op <= DSP_OPMODE;
      s_p  <= s_x + s_z;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_cmd(input logic [9:0] len);
    CMD_VALID = 1'b1;
    CMD_LEN   = len;
    #1;
    check("cmd_ready", CMD_READY, 1);
    tick();
    CMD_VALID = 1'b0;
  endtask

  task automatic send_pair(input logic [17:0] a, input logic [17:0] b, input logic [7:0] op);
    OP_VALID = 1'b1;
    OP_A     = a;
    OP_B     = b;
    #1;
    check("op_ready", OP_READY, 1);
    check("dsp_a", DSP_A, a);
    tick();
    OP_VALID = 1'b0;
    OP_A     = '0;
    OP_B     = '0;
    check("opmode_pair", DSP_OPMODE, op);
  endtask

  task automatic bubble();
    OP_VALID = 1'b0;
    tick();
    check("opmode_bubble", DSP_OPMODE, 8'h08);
  endtask

  task automatic expect_result(input int lat);
    logic [47:0] e;
    for (int i = 0; i < lat; i++) begin
      if (i == lat - 1) check("res_valid_early", RES_VALID, 0);
      tick();
    end
    check("res_valid", RES_VALID, 1);
    check("sb_nonempty", (exp_q.size() != 0), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("res", RES, e);
    end
  endtask

  task automatic accept_result();
    RES_READY = 1'b1;
    tick();
    RES_READY = 1'b0;
    check("res_valid_after", RES_VALID, 0);
    check("cmd_ready_after", CMD_READY, 1);
  endtask

  task automatic check_reset_outputs();
    check("rst_cmd_ready", CMD_READY, 1);
    check("rst_op_ready", OP_READY, 0);
    check("rst_res_valid", RES_VALID, 0);
    check("rst_res", RES, 0);
    check("rst_opmode", DSP_OPMODE, 8'h00);
    check("rst_ce", DSP_CE, 0);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check_reset_outputs();
    RST = 1'b0;
    tick();
    check("ce_after_reset", DSP_CE, 1);
    check("opmode_idle", DSP_OPMODE, 8'h08);

    // LEN=1, (3,5)
    start_cmd(10'd1);
    exp_q.push_back(48'd15);
    send_pair(18'd3, 18'd5, 8'h01);
    tick();
    check("opmode_after_single", DSP_OPMODE, 8'h08);
    expect_result(2);
    accept_result();

    // LEN=4 with two bubbles between pairs 2 and 3
    start_cmd(10'd4);
    exp_q.push_back(48'd100);
    send_pair(18'd1, 18'd2, 8'h01);
    send_pair(18'd3, 18'd4, 8'h09);
    bubble();
    bubble();
    send_pair(18'd5, 18'd6, 8'h09);
    send_pair(18'd7, 18'd8, 8'h09);
    expect_result(3);
    accept_result();

    // Back-to-back commands: second must not include the first sum
    start_cmd(10'd2);
    exp_q.push_back(48'd101);
    send_pair(18'd10, 18'd10, 8'h01);
    send_pair(18'd1, 18'd1, 8'h09);
    expect_result(3);
    accept_result();
    start_cmd(10'd1);
    exp_q.push_back(48'd4);
    send_pair(18'd2, 18'd2, 8'h01);
    expect_result(3);
    accept_result();

    // LEN=0
    start_cmd(10'd0);
    exp_q.push_back(48'd0);
    check("len0_op_ready", OP_READY, 0);
    expect_result(0);
    accept_result();

    // LEN=1023, full-scale operands
    start_cmd(10'd1023);
    exp_q.push_back(48'd70299488355327);
    for (int i = 0; i < 1023; i++) begin
      send_pair(18'd262143, 18'd262143, (i == 0) ? 8'h01 : 8'h09);
    end
    expect_result(3);
    accept_result();

    // Reset mid-FEED abandons the command
    start_cmd(10'd3);
    send_pair(18'd9, 18'd9, 8'h01);
    RST = 1'b1;
    #1;
    check_reset_outputs();
    tick();
    RST = 1'b0;
    tick();
    check("ce_after_reset2", DSP_CE, 1);

    // Next command after reset, result held with RES_READY low
    start_cmd(10'd1);
    exp_q.push_back(48'd16);
    send_pair(18'd4, 18'd4, 8'h01);
    expect_result(3);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_res_valid", RES_VALID, 1);
      check("hold_res", RES, 48'd16);
      check("hold_cmd_ready", CMD_READY, 0);
    end
    accept_result();

    check("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
